// File: rtl/vrf_pkg.sv
// Shared types and configuration checks for the VRF read-port controller.
// The optional stride feature is selected by VRF_RD_CTRL_STRIDE_EN (see vrf_read_ctrl).
package vrf_pkg;

   localparam int unsigned VRF_MEM_DEPTH = 512;
   localparam int unsigned VRF_AW        = $clog2(VRF_MEM_DEPTH);

   typedef logic [VRF_AW-1:0] vrf_addr_t;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_ISSUE,
      RD_DRAIN
   } vrf_rd_state_e;

   // The FIFO must absorb every read that can be in flight when the consumer stalls.
   function automatic bit vrf_rd_cfg_ok(input int unsigned fifo_depth,
                                        input int unsigned read_latency);
      return (read_latency >= 1) && (read_latency <= 8) &&
             (fifo_depth >= read_latency + 1);
   endfunction

endpackage

// File: rtl/vrf_rd_fifo.sv
// First-word-fall-through FIFO for returned {last, data} words.
// The output reads as zero while the FIFO is empty.
module vrf_rd_fifo
   import vrf_pkg::*;
#(
   parameter  int unsigned DW    = 33,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push_i,
   input  logic [DW-1:0] din_i,
   input  logic          pop_i,
   output logic [DW-1:0] dout_o,
   output logic          valid_o,
   output logic [CW-1:0] count_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wp_q;
   logic [PW-1:0] rp_q;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_o <= '0;
      end else begin
         if (push_i) wp_q <= next_ptr(wp_q);
         if (pop_i)  rp_q <= next_ptr(rp_q);
         count_o <= count_o + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem[wp_q] <= din_i;
   end

   assign valid_o = (count_o != '0);
   assign dout_o  = valid_o ? mem[rp_q] : '0;

endmodule

// File: rtl/vrf_read_ctrl.sv
// Operand fetch engine for one VRF read port: issues element reads, tracks the
// read latency and buffers returned words. Define VRF_RD_CTRL_STRIDE_EN for strided access.
module vrf_read_ctrl
   import vrf_pkg::*;
#(
   parameter  int unsigned MEM_DEPTH    = 512,
   parameter  int unsigned MEM_WIDTH    = 32,
   parameter  int unsigned READ_LATENCY = 3,
   parameter  int unsigned FIFO_DEPTH   = 4,
   parameter  int unsigned LEN_W        = 10,
   localparam int unsigned AW           = $clog2(MEM_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start_i,
   input  logic [AW-1:0]        base_addr_i,
`ifdef VRF_RD_CTRL_STRIDE_EN
   input  logic [AW-1:0]        stride_i,
`endif
   input  logic [LEN_W-1:0]     len_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [AW-1:0]        raddr_o,
   output logic                 ren_o,
   output logic                 oreg_en_o,
   input  logic [MEM_WIDTH-1:0] rdata_i,
   output logic [MEM_WIDTH-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 last_o
);

   localparam int unsigned FCW   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

   if (!vrf_rd_cfg_ok(FIFO_DEPTH, READ_LATENCY)) begin : g_bad_cfg
      $error("vrf_read_ctrl: need 1 <= READ_LATENCY <= 8 and FIFO_DEPTH >= READ_LATENCY+1");
   end

   logic [AW-1:0] stride_in;
`ifdef VRF_RD_CTRL_STRIDE_EN
   assign stride_in = stride_i;
`else
   assign stride_in = AW'(1);
`endif

   vrf_rd_state_e state_q, state_d;

   logic [LEN_W-1:0]        len_q;
   logic [LEN_W-1:0]        idx_q;
   logic [AW-1:0]           acc_q;
   logic [AW-1:0]           stride_q;
   logic                    ren_last_q;
   logic [READ_LATENCY-1:0] pv_q;
   logic [READ_LATENCY-1:0] pl_q;

   logic            issue;
   logic            issue_last;
   logic [AW-1:0]   issue_addr;
   logic            done_d;
   logic            credit;
   logic [CNT_W-1:0] inflight;
   logic [FCW-1:0]  fifo_count;
   logic            fifo_last;
   logic            pop;

   always_comb begin
      inflight = CNT_W'(ren_o);
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
         inflight = inflight + CNT_W'(pv_q[i]);
      end
   end

   assign credit = (CNT_W'(fifo_count) + inflight) < CNT_W'(FIFO_DEPTH);
   assign pop    = valid_o & ready_i;

   // Element 0 is issued straight from IDLE so ren_o follows start_i by one cycle.
   always_comb begin
      state_d    = state_q;
      issue      = 1'b0;
      issue_last = 1'b0;
      issue_addr = acc_q;
      done_d     = 1'b0;
      case (state_q)
         RD_IDLE: begin
            issue_addr = base_addr_i;
            issue_last = (len_i == LEN_W'(1));
            if (start_i) begin
               if (len_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  issue   = 1'b1;
                  state_d = (len_i == LEN_W'(1)) ? RD_DRAIN : RD_ISSUE;
               end
            end
         end
         RD_ISSUE: begin
            issue_last = (idx_q == len_q - LEN_W'(1));
            if (credit) begin
               issue = 1'b1;
               if (issue_last) state_d = RD_DRAIN;
            end
         end
         RD_DRAIN: begin
            if (pop && fifo_last) begin
               done_d  = 1'b1;
               state_d = RD_IDLE;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= RD_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ren_o      <= 1'b0;
         ren_last_q <= 1'b0;
         raddr_o    <= '0;
         done_o     <= 1'b0;
         len_q      <= '0;
         idx_q      <= '0;
         acc_q      <= '0;
         stride_q   <= '0;
      end else begin
         ren_o      <= issue;
         ren_last_q <= issue & issue_last;
         done_o     <= done_d;
         if (issue) raddr_o <= issue_addr;
         if (state_q == RD_IDLE && start_i) begin
            len_q    <= len_i;
            stride_q <= stride_in;
            acc_q    <= base_addr_i + stride_in;
            idx_q    <= LEN_W'(1);
         end else if (state_q == RD_ISSUE && issue) begin
            acc_q <= acc_q + stride_q;
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   // pv_q[k] marks a read issued k+1 cycles ago; the tail lines up with rdata_i.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pv_q <= '0;
         pl_q <= '0;
      end else begin
         pv_q[0] <= ren_o;
         pl_q[0] <= ren_last_q;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1];
            pl_q[i] <= pl_q[i-1];
         end
      end
   end

   if (READ_LATENCY == 1) begin : g_oreg_direct
      assign oreg_en_o = ren_o;
   end else begin : g_oreg_pipe
      assign oreg_en_o = pv_q[READ_LATENCY-2];
   end

   vrf_rd_fifo #(
      .DW    (MEM_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (pv_q[READ_LATENCY-1]),
      .din_i   ({pl_q[READ_LATENCY-1], rdata_i}),
      .pop_i   (pop),
      .dout_o  ({fifo_last, data_o}),
      .valid_o (valid_o),
      .count_o (fifo_count)
   );

   assign last_o = fifo_last;
   assign busy_o = (state_q != RD_IDLE);

endmodule

// File: tb/tb_vrf_read_ctrl.sv
// Self-checking bench for vrf_read_ctrl: a VRF latency model, an element-level
// scoreboard checked every cycle, directed literal cases and randomized commands.
module tb_vrf_read_ctrl;

   localparam int MD = 512;
   localparam int MW = 32;
   localparam int RL = 3;
   localparam int FD = 4;
   localparam int LW = 10;
   localparam int AW = $clog2(MD);

   logic          clk = 1'b0;
   logic          rstn;
   logic          start_i;
   logic [AW-1:0] base_addr_i;
   logic [AW-1:0] stride;
   logic [LW-1:0] len_i;
   logic          busy_o, done_o, ren_o, oreg_en_o, valid_o, ready_i, last_o;
   logic [AW-1:0] raddr_o;
   logic [MW-1:0] rdata_i, data_o;

   always #5 clk = ~clk;

   vrf_read_ctrl #(
      .MEM_DEPTH    (MD),
      .MEM_WIDTH    (MW),
      .READ_LATENCY (RL),
      .FIFO_DEPTH   (FD),
      .LEN_W        (LW)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
`ifdef VRF_RD_CTRL_STRIDE_EN
      .stride_i    (stride),
`endif
      .len_i       (len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .raddr_o     (raddr_o),
      .ren_o       (ren_o),
      .oreg_en_o   (oreg_en_o),
      .rdata_i     (rdata_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .last_o      (last_o)
   );

   // VRF model: data for the address presented with ren_o is visible RL cycles later.
   logic [MW-1:0] mem [MD];
   logic [AW-1:0] a_pipe [RL];
   always @(posedge clk) begin
      a_pipe[0] <= raddr_o;
      for (int i = 1; i < RL; i++) a_pipe[i] <= a_pipe[i-1];
   end
   assign rdata_i = mem[a_pipe[RL-1]];

   int n_vec = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   int cyc = 0;
   bit rst_edge = 1'b1;
   always @(posedge clk) begin
      cyc++;
      rst_edge = !rstn;
   end

   // Scoreboard state: current command seen at element granularity.
   bit m_busy = 1'b0;
   bit m_done_due = 1'b0;
   int m_base = 0, m_stride = 1, m_len = 0, m_iss = 0, m_acc = 0;
   bit ren_hist [8];
   bit prev_stall = 1'b0;
   logic [MW-1:0] prev_data;
   bit prev_last;
   int ren_addr_q[$];
   int ren_cyc_q[$];
   int val_cyc_q[$];
   int hs_cyc_q[$];
   int done_cyc_q[$];

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -999;
   endfunction

   always @(negedge clk) begin
      bit busy_now;
      bit nxt_done;
      int ea;
      if (rst_edge) begin
         chk("rst_flags", {busy_o, done_o, ren_o, oreg_en_o, valid_o, last_o}, 0);
         chk("rst_raddr", raddr_o, 0);
         chk("rst_data", data_o, 0);
         m_busy = 0; m_done_due = 0; m_iss = 0; m_acc = 0; m_len = 0;
         prev_stall = 0;
         for (int i = 0; i < 8; i++) ren_hist[i] = 0;
      end else begin
         busy_now = m_busy;
         nxt_done = 0;
         chk("busy", busy_o, m_busy);
         chk("done", done_o, m_done_due);
         if (done_o) done_cyc_q.push_back(cyc);
         chk("oreg_en", oreg_en_o, (RL == 1) ? ren_o : ren_hist[RL-2]);
         if (prev_stall) begin
            chk("stall_valid", valid_o, 1);
            chk("stall_data", data_o, prev_data);
            chk("stall_last", last_o, prev_last);
         end
         if (ren_o) begin
            chk("ren_within_len", m_iss < m_len, 1);
            ea = (m_base + m_iss * m_stride) % MD;
            chk("raddr", raddr_o, ea);
            m_iss++;
            chk("credit_bound", (m_iss - m_acc) <= FD, 1);
            ren_addr_q.push_back(int'(raddr_o));
            ren_cyc_q.push_back(cyc);
         end
         if (valid_o) begin
            chk("valid_pending", m_acc < m_iss, 1);
            ea = (m_base + m_acc * m_stride) % MD;
            chk("data", data_o, mem[ea]);
            chk("last", last_o, m_acc == m_len - 1);
            val_cyc_q.push_back(cyc);
            if (ready_i) begin
               hs_cyc_q.push_back(cyc);
               m_acc++;
               if (m_acc == m_len) begin
                  nxt_done = 1;
                  m_busy = 0;
               end
            end
         end
         prev_stall = valid_o && !ready_i;
         prev_data  = data_o;
         prev_last  = last_o;
         if (start_i && !busy_now) begin
            m_base = int'(base_addr_i);
            m_stride = int'(stride);
            m_len = int'(len_i);
            m_iss = 0;
            m_acc = 0;
            if (m_len == 0) nxt_done = 1;
            else m_busy = 1;
         end
         m_done_due = nxt_done;
         for (int i = 7; i > 0; i--) ren_hist[i] = ren_hist[i-1];
         ren_hist[0] = ren_o;
      end
   end

   bit rand_ready = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
   endtask

   task automatic start_cmd(input int b, input int l, input int s, output int sc);
      base_addr_i = AW'(b);
      len_i = LW'(l);
      stride = AW'(s);
      start_i = 1'b1;
      sc = cyc;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int max);
      int k = 0;
      while (done_cyc_q.size() == d0 && k < max) begin
         tick();
         k++;
      end
      chk("done_seen", done_cyc_q.size() - d0, 1);
   endtask

   initial begin
      int sc, r0, v0, d0, h0;
      int exp_a [4];
      rstn = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0;
      stride = AW'(1); ready_i = 1'b1;
      for (int i = 0; i < MD; i++) mem[i] = $urandom;
      repeat (3) tick();
      rstn = 1'b1;
      tick();

      // base 0x010, len 4, consumer always ready
      r0 = ren_cyc_q.size(); v0 = val_cyc_q.size(); d0 = done_cyc_q.size(); h0 = hs_cyc_q.size();
      start_cmd(32'h010, 4, 1, sc);
      wait_done(d0, 100);
      chk("t1_nren", ren_cyc_q.size() - r0, 4);
      for (int k = 0; k < 4; k++) begin
         chk("t1_addr", qget(ren_addr_q, r0 + k), 32'h010 + k);
         chk("t1_ren_cyc", qget(ren_cyc_q, r0 + k) - sc, 1 + k);
      end
      chk("t1_first_valid", qget(val_cyc_q, v0) - sc, 5);
      chk("t1_nhs", hs_cyc_q.size() - h0, 4);
      chk("t1_done_after_hs", qget(done_cyc_q, d0) - qget(hs_cyc_q, h0 + 3), 1);
      chk("t1_done_abs", qget(done_cyc_q, d0) - sc, 9);
      tick();

      // wrap at the top of the address space
      r0 = ren_cyc_q.size(); d0 = done_cyc_q.size();
      exp_a[0] = 32'h1FE; exp_a[1] = 32'h1FF; exp_a[2] = 32'h000; exp_a[3] = 32'h001;
      start_cmd(32'h1FE, 4, 1, sc);
      wait_done(d0, 100);
      for (int k = 0; k < 4; k++) chk("t2_wrap_addr", qget(ren_addr_q, r0 + k), exp_a[k]);
      tick();

      // consumer stalled: issue stops at the FIFO credit limit
      r0 = ren_cyc_q.size(); d0 = done_cyc_q.size(); h0 = hs_cyc_q.size();
      ready_i = 1'b0;
      start_cmd(32'h100, 8, 1, sc);
      repeat (30) tick();
      chk("t3_nren_stalled", ren_cyc_q.size() - r0, 4);
      chk("t3_no_hs", hs_cyc_q.size() - h0, 0);
      chk("t3_valid_held", valid_o, 1);
      ready_i = 1'b1;
      wait_done(d0, 100);
      repeat (4) tick();
      chk("t3_nren", ren_cyc_q.size() - r0, 8);
      chk("t3_nhs", hs_cyc_q.size() - h0, 8);
      chk("t3_ndone", done_cyc_q.size() - d0, 1);

      // zero-length command
      r0 = ren_cyc_q.size(); v0 = val_cyc_q.size(); d0 = done_cyc_q.size();
      start_cmd(32'h055, 0, 1, sc);
      wait_done(d0, 20);
      chk("t4_done_lat", qget(done_cyc_q, d0) - sc, 1);
      repeat (3) tick();
      chk("t4_nren", ren_cyc_q.size() - r0, 0);
      chk("t4_nvalid", val_cyc_q.size() - v0, 0);

      // reset in the middle of a long burst
      d0 = done_cyc_q.size();
      start_cmd(32'h040, 16, 1, sc);
      repeat (6) tick();
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      repeat (3) tick();
      chk("t5_no_done", done_cyc_q.size() - d0, 0);
      h0 = hs_cyc_q.size();
      start_cmd(32'h070, 2, 1, sc);
      wait_done(d0, 50);
      chk("t5_nhs", hs_cyc_q.size() - h0, 2);
      tick();

`ifdef VRF_RD_CTRL_STRIDE_EN
      r0 = ren_cyc_q.size(); d0 = done_cyc_q.size();
      start_cmd(4, 3, 3, sc);
      wait_done(d0, 50);
      chk("t6_stride_a0", qget(ren_addr_q, r0), 4);
      chk("t6_stride_a1", qget(ren_addr_q, r0 + 1), 7);
      chk("t6_stride_a2", qget(ren_addr_q, r0 + 2), 10);
      tick();
`endif

      // randomized commands, random back-pressure, ignored starts while busy
      rand_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         int k;
         int s;
`ifdef VRF_RD_CTRL_STRIDE_EN
         s = $urandom_range(0, MD - 1);
`else
         s = 1;
`endif
         repeat ($urandom_range(0, 3)) tick();
         d0 = done_cyc_q.size();
         start_cmd($urandom_range(0, MD - 1), $urandom_range(0, 20), s, sc);
         k = 0;
         while (done_cyc_q.size() == d0 && k < 500) begin
            if (m_busy && $urandom_range(0, 7) == 0) begin
               base_addr_i = AW'($urandom);
               len_i = LW'($urandom);
               start_i = 1'b1;
            end
            tick();
            start_i = 1'b0;
            k++;
         end
         chk("rand_done_seen", done_cyc_q.size() - d0, 1);
      end
      rand_ready = 1'b0;
      ready_i = 1'b1;
      repeat (10) tick();
      chk("final_idle", busy_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
